// File: rtl/dcache_freeze_ctrl.sv
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache that freezes the pipeline during fills and writes.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_freeze_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cache_en,
  input  logic        mem_write,
  input  logic        is_LB_SB,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [31:0]      fill_q;

  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             is_load;
  logic             is_store;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d;

  logic start_fill, start_write, fill_done, write_done;

  assign idx      = addr[IDX+1:2];
  assign addr_tag = addr[31:IDX+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign is_load  = cache_en && !mem_write;
  assign is_store = cache_en && mem_write;
  assign be_d     = is_LB_SB ? (4'b0001 << addr[1:0]) : 4'hF;
  assign wdata_d  = is_LB_SB ? {4{wdata[7:0]}} : wdata;

  // Word or sign-extended little-endian byte, as the load type asks.
  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic byte_op,
                                           input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return byte_op ? {{24{b[7]}}, b} : word;
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    freeze      = 1'b0;
    rdata       = '0;
    start_fill  = 1'b0;
    start_write = 1'b0;
    fill_done   = 1'b0;
    write_done  = 1'b0;
    if (rst_b) begin
      case (state_q)
        S_IDLE: begin
          if (is_load) begin
            if (hit) begin
              rdata = load_fmt(data_q[idx], is_LB_SB, addr[1:0]);
            end else begin
              freeze     = 1'b1;
              start_fill = 1'b1;
              state_d    = S_FILL;
            end
          end else if (is_store) begin
            freeze      = 1'b1;
            start_write = 1'b1;
            state_d     = S_WRITE;
          end
        end
        S_FILL: begin
          freeze = 1'b1;
          if (mem_ack) begin
            fill_done = 1'b1;
            state_d   = S_RESP;
          end
        end
        S_WRITE: begin
          freeze = 1'b1;
          if (mem_ack) begin
            write_done = 1'b1;
            state_d    = S_RESP;
          end
        end
        default: begin
          // One-cycle release: the frozen load completes from the captured fill word.
          if (is_load) rdata = load_fmt(fill_q, is_LB_SB, addr[1:0]);
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      valid_q   <= '0;
      fill_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      if (start_fill) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= '0;
        mem_be    <= 4'hF;
      end
      if (start_write) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= wdata_d;
        mem_be    <= be_d;
      end
      if (fill_done || write_done) mem_req <= 1'b0;
      if (fill_done) begin
        valid_q[idx] <= 1'b1;
        fill_q       <= mem_rdata;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= addr_tag;
    end
    if (start_write && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) data_q[idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == S_IDLE && cache_en) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
